// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of pwm_i in clk_i cycles, one registered result per period.
// Optional 3-sample glitch filter on the synchronized level, enabled by defining PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture #(
  parameter int RESOLUTION = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  pwm_i,
  output logic [RESOLUTION-1:0] duty_o,
  output logic [RESOLUTION-1:0] period_o,
  output logic                  valid_o,
  output logic                  stuck_o
);

  localparam logic [1:0] ST_WAIT_RISE = 2'd0;
  localparam logic [1:0] ST_HIGH      = 2'd1;
  localparam logic [1:0] ST_LOW       = 2'd2;

  localparam logic [RESOLUTION-1:0] CNT_MAX  = {RESOLUTION{1'b1}};
  localparam logic [RESOLUTION-1:0] CNT_ZERO = {RESOLUTION{1'b0}};
  localparam logic [RESOLUTION-1:0] CNT_ONE  = {{(RESOLUTION-1){1'b0}}, 1'b1};

  logic                  sync1_q, sync2_q;
  logic                  lvl, lvl_d_q;
  logic                  rise, fall;
  logic [1:0]            state_q, state_d;
  logic [RESOLUTION-1:0] cnt_period_q, cnt_period_d;
  logic [RESOLUTION-1:0] cnt_high_q, cnt_high_d;
  logic [RESOLUTION-1:0] duty_q, duty_d;
  logic [RESOLUTION-1:0] period_q, period_d;
  logic                  valid_q, valid_d;
  logic                  stuck_q, stuck_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pwm_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic hist1_q, hist2_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hist1_q <= 1'b0;
      hist2_q <= 1'b0;
    end else begin
      hist1_q <= sync2_q;
      hist2_q <= hist1_q;
    end
  end

  // lvl_d_q doubles as the filter's held value; lvl only moves on 3 agreeing samples.
  always_comb begin
    lvl = lvl_d_q;
    if (sync2_q && hist1_q && hist2_q) begin
      lvl = 1'b1;
    end else if (!sync2_q && !hist1_q && !hist2_q) begin
      lvl = 1'b0;
    end
  end
`else
  assign lvl = sync2_q;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lvl_d_q <= 1'b0;
    end else begin
      lvl_d_q <= lvl;
    end
  end

  assign rise = lvl && !lvl_d_q;
  assign fall = !lvl && lvl_d_q;

  always_comb begin
    state_d      = state_q;
    cnt_period_d = cnt_period_q;
    cnt_high_d   = cnt_high_q;
    duty_d       = duty_q;
    period_d     = period_q;
    stuck_d      = stuck_q;
    valid_d      = 1'b0;

    case (state_q)
      ST_WAIT_RISE: begin
        if (rise) begin
          cnt_period_d = CNT_ONE;
          cnt_high_d   = CNT_ONE;
          state_d      = ST_HIGH;
        end
      end

      ST_HIGH: begin
        if (cnt_period_q == CNT_MAX) begin
          duty_d   = CNT_MAX;
          period_d = CNT_MAX;
          stuck_d  = 1'b1;
          valid_d  = 1'b1;
          state_d  = ST_WAIT_RISE;
        end else if (fall) begin
          cnt_period_d = cnt_period_q + CNT_ONE;
          state_d      = ST_LOW;
        end else begin
          cnt_period_d = cnt_period_q + CNT_ONE;
          cnt_high_d   = cnt_high_q + CNT_ONE;
        end
      end

      ST_LOW: begin
        // An edge landing on the threshold cycle is still a real period.
        if (rise) begin
          duty_d       = cnt_high_q;
          period_d     = cnt_period_q;
          stuck_d      = 1'b0;
          valid_d      = 1'b1;
          cnt_period_d = CNT_ONE;
          cnt_high_d   = CNT_ONE;
          state_d      = ST_HIGH;
        end else if (cnt_period_q == CNT_MAX) begin
          duty_d   = CNT_ZERO;
          period_d = CNT_MAX;
          stuck_d  = 1'b1;
          valid_d  = 1'b1;
          state_d  = ST_WAIT_RISE;
        end else begin
          cnt_period_d = cnt_period_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_WAIT_RISE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_WAIT_RISE;
      cnt_period_q <= CNT_ZERO;
      cnt_high_q   <= CNT_ZERO;
      duty_q       <= CNT_ZERO;
      period_q     <= CNT_ZERO;
      valid_q      <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_period_q <= cnt_period_d;
      cnt_high_q   <= cnt_high_d;
      duty_q       <= duty_d;
      period_q     <= period_d;
      valid_q      <= valid_d;
      stuck_q      <= stuck_d;
    end
  end

  assign duty_o   = duty_q;
  assign period_o = period_q;
  assign valid_o  = valid_q;
  assign stuck_o  = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a 16-bit and an 8-bit instance share one stimulus stream;
// every valid_o strobe is queued and compared against hand-computed results.
module tb_pwm_capture;

  logic clk_i = 1'b0;
  logic reset_i;
  logic pwm_i;

  logic [15:0] duty16, period16;
  logic        valid16, stuck16;
  logic [7:0]  duty8, period8;
  logic        valid8, stuck8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int duty;
    int period;
    int stuck;
    int cyc;
  } res_t;

  typedef struct {
    int hi;
    int lo;
    int reps;
    int exp_duty;
    int exp_period;
  } vec_t;

  res_t q16[$];
  res_t q8[$];
  res_t r16, r8;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  pwm_capture #(.RESOLUTION(16)) dut16 (
    .clk_i(clk_i), .reset_i(reset_i), .pwm_i(pwm_i),
    .duty_o(duty16), .period_o(period16), .valid_o(valid16), .stuck_o(stuck16)
  );

  pwm_capture #(.RESOLUTION(8)) dut8 (
    .clk_i(clk_i), .reset_i(reset_i), .pwm_i(pwm_i),
    .duty_o(duty8), .period_o(period8), .valid_o(valid8), .stuck_o(stuck8)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (valid16 === 1'b1) begin
      r16.duty = int'(duty16);
      r16.period = int'(period16);
      r16.stuck = int'(stuck16);
      r16.cyc = cyc;
      q16.push_back(r16);
    end
    if (valid8 === 1'b1) begin
      r8.duty = int'(duty8);
      r8.period = int'(period8);
      r8.stuck = int'(stuck8);
      r8.cyc = cyc;
      q8.push_back(r8);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic expect16(input string nm, input int ed, input int ep, input int es);
    res_t r;
    if (q16.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no result from 16-bit instance, expected duty=%0d period=%0d", nm, ed, ep);
    end else begin
      r = q16.pop_front();
      chk({nm, ".duty"}, r.duty, ed);
      chk({nm, ".period"}, r.period, ep);
      chk({nm, ".stuck"}, r.stuck, es);
    end
  endtask

  task automatic expect8(input string nm, input int ed, input int ep, input int es);
    res_t r;
    if (q8.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no result from 8-bit instance, expected duty=%0d period=%0d", nm, ed, ep);
    end else begin
      r = q8.pop_front();
      chk({nm, ".duty"}, r.duty, ed);
      chk({nm, ".period"}, r.period, ep);
      chk({nm, ".stuck"}, r.stuck, es);
    end
  endtask

  // Level is applied just after a rising edge and sampled on the next n edges.
  task automatic drive(input logic lv, input int n);
    pwm_i = lv;
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    vec_t vecs[6];
    int   n_vec;
    int   n_start;
    res_t lr;

    vecs[0] = '{3, 5, 4, 3, 8};
    vecs[1] = '{4, 3, 3, 4, 7};
    vecs[2] = '{3, 3, 3, 3, 6};
    vecs[3] = '{12, 7, 3, 12, 19};
    vecs[4] = '{5, 40, 2, 5, 45};
    vecs[5] = '{1, 1, 4, 1, 2};
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    n_vec = 5;
`else
    n_vec = 6;
`endif

    // Reset state
    reset_i = 1'b1;
    pwm_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst.duty16", int'(duty16), 0);
    chk("rst.period16", int'(period16), 0);
    chk("rst.valid16", int'(valid16), 0);
    chk("rst.stuck16", int'(stuck16), 0);
    chk("rst.duty8", int'(duty8), 0);
    chk("rst.period8", int'(period8), 0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    @(negedge clk_i);
    chk("rel.valid16", int'(valid16), 0);
    chk("rel.stuck8", int'(stuck8), 0);
    @(posedge clk_i);
    #1;

    // Table-driven steady waveforms
    drive(1'b0, 4);
    for (int v = 0; v < n_vec; v++) begin
      for (int r = 0; r < vecs[v].reps; r++) begin
        drive(1'b1, vecs[v].hi);
        drive(1'b0, vecs[v].lo);
      end
    end
    drive(1'b1, 4);
    drive(1'b0, 8);
    for (int v = 0; v < n_vec; v++) begin
      for (int r = 0; r < vecs[v].reps; r++) begin
        expect16($sformatf("vec%0d.r%0d.w16", v, r), vecs[v].exp_duty, vecs[v].exp_period, 0);
        expect8($sformatf("vec%0d.r%0d.w8", v, r), vecs[v].exp_duty, vecs[v].exp_period, 0);
      end
    end
    chk("vec.extra16", q16.size(), 0);
    chk("vec.extra8", q8.size(), 0);

    // Asynchronous reset in the middle of a high phase
    drive(1'b1, 5);
    #3;
    reset_i = 1'b1;
    #1;
    chk("arst.duty16", int'(duty16), 0);
    chk("arst.period16", int'(period16), 0);
    chk("arst.valid16", int'(valid16), 0);
    chk("arst.stuck16", int'(stuck16), 0);
    pwm_i = 1'b0;
    repeat (2) begin
      @(posedge clk_i);
      #1;
    end
    reset_i = 1'b0;
    q16.delete();
    q8.delete();
    drive(1'b0, 3);
    drive(1'b1, 10);
    drive(1'b0, 10);
    chk("arst.no_early_result", q16.size(), 0);
    chk("arst.duty_held", int'(duty16), 0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 10);
      drive(1'b0, 10);
    end
    drive(1'b1, 6);
    drive(1'b0, 6);
    for (int i = 0; i < 3; i++) expect16($sformatf("arst.p%0d", i), 10, 20, 0);
    chk("arst.extra16", q16.size(), 0);

    // Held low after a period: 8-bit instance times out with 0 % duty
    q16.delete();
    q8.delete();
    drive(1'b0, 300);
    expect8("low_to", 0, 255, 1);
    chk("low_to.count8", q8.size(), 0);
    chk("low_to.count16", q16.size(), 0);
    @(negedge clk_i);
    chk("low_to.hold_duty8", int'(duty8), 0);
    chk("low_to.hold_period8", int'(period8), 255);
    chk("low_to.hold_stuck8", int'(stuck8), 1);
    chk("low_to.hold_valid8", int'(valid8), 0);
    @(posedge clk_i);
    #1;

    // Held high: 8-bit instance reports 100 % duty; 16-bit one measures the long period
    q16.delete();
    q8.delete();
    drive(1'b1, 300);
    expect8("high_to", 255, 255, 1);
    chk("high_to.count8", q8.size(), 0);
    expect16("long_period", 6, 313, 0);

    // Resume 4/4 after the timeout: two rising edges before the first result
    drive(1'b0, 4);
    chk("resume.fall_ignored", q8.size(), 0);
    q16.delete();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4);
      drive(1'b0, 4);
    end
    drive(1'b1, 4);
    drive(1'b0, 8);
    for (int i = 0; i < 3; i++) expect8($sformatf("resume.p%0d", i), 4, 8, 0);
    chk("resume.extra8", q8.size(), 0);

    // Latency from the first high sample to valid_o
    q16.delete();
    n_start = cyc;
    drive(1'b1, 3);
    drive(1'b0, 5);
    if (q16.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL latency: no strobe seen, expected one %0d cycles after the first sample", LAT);
    end else begin
      lr = q16.pop_front();
      chk("latency.cycles", lr.cyc - n_start, LAT);
      chk("latency.duty", lr.duty, 4);
      chk("latency.period", lr.period, 12);
    end

    // One-cycle glitch inside a low phase of a 6/6 waveform
    drive(1'b1, 6);
    q16.delete();
    drive(1'b0, 6);
    drive(1'b1, 6);
    drive(1'b0, 2);
    drive(1'b1, 1);
    drive(1'b0, 3);
    drive(1'b1, 6);
    drive(1'b0, 6);
    drive(1'b1, 6);
    drive(1'b0, 6);
    expect16("glitch.p0", 6, 12, 0);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    expect16("glitch.p1", 6, 12, 0);
`else
    expect16("glitch.p1", 6, 8, 0);
    expect16("glitch.p2", 1, 4, 0);
`endif
    expect16("glitch.p3", 6, 12, 0);
    chk("glitch.extra16", q16.size(), 0);

    // Timeout threshold on the 8-bit instance: 255 measures, 256 times out
    drive(1'b1, 100);
    q8.delete();
    drive(1'b0, 155);
    drive(1'b1, 100);
    drive(1'b0, 156);
    drive(1'b1, 20);
    drive(1'b0, 20);
    expect8("edge_at_max", 100, 255, 0);
    expect8("past_max", 0, 255, 1);
    chk("past_max.no_restart_result", q8.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
